// File: rtl/mux8_scan_pkg.sv
// Shared types and helpers for the 8:1 mux scan controller: FSM encoding,
// channel-to-select mapping and the legal dwell range.
package mux8_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 15;

    typedef struct packed {
        logic s2;
        logic s1;
        logic s0;
    } sel_t;

    // The mux wiring swaps the two low select bits relative to the channel index.
    function automatic sel_t chan_to_sel(input logic [2:0] c);
        sel_t s;
        s.s2 = c[2];
        s.s0 = c[1];
        s.s1 = c[0];
        return s;
    endfunction

endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// Valid/ready sample stream carrying a captured mux word and its channel index.
interface mux8_scan_ctrl_if #(
    parameter int DW = 16
);
    logic [DW-1:0] out_data;
    logic [2:0]    out_chan;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, out_chan, out_valid, input out_ready);
    modport slave  (input out_data, out_chan, out_valid, output out_ready);
endinterface

// File: rtl/mux8_next_chan.sv
// Combinational channel search: lowest enabled channel, and the next enabled
// channel strictly above cur (no wrap).
module mux8_next_chan (
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] nxt,
    output logic [2:0] first,
    output logic       has_next
);
    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        nxt      = '0;
        first    = '0;
        has_next = 1'b0;
        // Walking downward lets the lowest qualifying index overwrite the rest.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                first = 3'(i);
                if (i > int'(cur)) begin
                    nxt      = 3'(i);
                    has_next = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mux8_scan_ctrl.sv
// Round-robin scan controller: steps the mux selects over the enabled channels,
// waits DWELL cycles per channel, then offers each capture on a valid/ready port.
module mux8_scan_ctrl
    import mux8_scan_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DWELL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [7:0]            chan_mask,
    output logic                  s0,
    output logic                  s1,
    output logic                  s2,
    input  logic [DW-1:0]         mux_data,
    mux8_scan_ctrl_if.master      out_if,
    output logic                  busy,
    output logic                  done
);
    localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       stop_pend;
    logic [7:0] mask_q;
    logic       cont_q;
    logic [2:0] chan;
    sel_t       sel;

    logic [7:0] search_mask;
    logic [2:0] nxt;
    logic [2:0] first;
    logic       has_next;
    logic       stop_now;
    logic       handshake;
    logic       end_scan;
    logic [2:0] target;

    // In IDLE the search looks at the live mask so the first channel is ready at start.
    assign search_mask = (state == IDLE) ? chan_mask : mask_q;

    mux8_next_chan u_next_chan (
        .mask     (search_mask),
        .cur      (chan),
        .nxt      (nxt),
        .first    (first),
        .has_next (has_next)
    );

    assign stop_now  = stop | stop_pend;
    assign handshake = out_if.out_valid && out_if.out_ready;
    assign end_scan  = ((state == SETTLE) && stop_now) ||
                       ((state == HOLD) && handshake && (stop_now || (!has_next && !cont_q)));
    assign target    = has_next ? nxt : first;

    assign s0 = sel.s0;
    assign s1 = sel.s1;
    assign s2 = sel.s2;

    always_ff @(posedge clk) begin
        // NOTE: every register is cleared by reset, including the latched mask, so a
        // reset mid-HOLD discards the pending sample and nothing starts up unknown.
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            stop_pend        <= 1'b0;
            mask_q           <= '0;
            cont_q           <= 1'b0;
            chan             <= '0;
            sel              <= '0;
            out_if.out_data  <= '0;
            out_if.out_chan  <= '0;
            out_if.out_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block override
            // earlier defaults on the same edge.
            done <= 1'b0;
            if (state != IDLE) begin
                stop_pend <= stop_pend | stop;
            end

            if (end_scan) begin
                state            <= IDLE;
                busy             <= 1'b0;
                done             <= 1'b1;
                stop_pend        <= 1'b0;
                out_if.out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (chan_mask == '0) begin
                                done <= 1'b1;
                            end else begin
                                mask_q <= chan_mask;
                                cont_q <= continuous;
                                chan   <= first;
                                sel    <= chan_to_sel(first);
                                cnt    <= CNT_LOAD;
                                busy   <= 1'b1;
                                state  <= SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            out_if.out_data  <= mux_data;
                            out_if.out_chan  <= chan;
                            out_if.out_valid <= 1'b1;
                            state            <= HOLD;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    HOLD: begin
                        if (handshake) begin
                            out_if.out_valid <= 1'b0;
                            chan             <= target;
                            sel              <= chan_to_sel(target);
                            cnt              <= CNT_LOAD;
                            state            <= SETTLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Self-checking bench for mux8_scan_ctrl: a queue-based scan model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mux8_scan_ctrl;
    localparam int DW    = 16;
    localparam int DWELL = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          continuous = 1'b0;
    logic [7:0]    chan_mask  = '0;
    logic          s0, s1, s2;
    logic [DW-1:0] mux_data;
    logic          busy, done;
    logic [DW-1:0] words [8];

    mux8_scan_ctrl_if #(.DW(DW)) bus ();

    mux8_scan_ctrl #(.DW(DW), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .chan_mask  (chan_mask),
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .mux_data   (mux_data),
        .out_if     (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // The mux: channel index is {s2, s0, s1}.
    always_comb mux_data = words[{s2, s0, s1}];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy, m_valid, m_done, m_pend, m_cont;
    logic [7:0]  m_mask;
    logic [2:0]  m_cur, m_sel, m_chan;
    logic [15:0] m_data;
    int          m_settle;
    int          plan [$];

    task automatic load_plan(input logic [7:0] m);
        plan.delete();
        for (int c = 0; c < 8; c++) if (m[c]) plan.push_back(c);
    endtask

    task automatic visit_next();
        m_cur    = 3'(plan.pop_front());
        m_sel    = m_cur;
        m_settle = DWELL;
    endtask

    task automatic m_finish();
        m_busy  = 0;
        m_valid = 0;
        m_done  = 1;
        m_pend  = 0;
        plan.delete();
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_pend = 0; m_cont = 0;
            m_mask = 0; m_cur = 0; m_sel = 0; m_chan = 0; m_data = 0; m_settle = 0;
            plan.delete();
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    if (chan_mask == 0) m_done = 1;
                    else begin
                        m_mask = chan_mask;
                        m_cont = continuous;
                        m_busy = 1;
                        load_plan(m_mask);
                        visit_next();
                    end
                end
            end else if (!m_valid) begin
                if (m_pend || stop) m_finish();
                else begin
                    m_settle--;
                    if (m_settle == 0) begin
                        m_valid = 1;
                        m_chan  = m_cur;
                        m_data  = words[m_cur];
                    end
                end
            end else if (bus.out_ready) begin
                m_valid = 0;
                if (m_pend || stop) m_finish();
                else if (plan.size() > 0) visit_next();
                else if (m_cont) begin
                    load_plan(m_mask);
                    visit_next();
                end else m_finish();
            end else begin
                m_pend = m_pend | stop;
            end
        end
    end

    // ---------------- observation logs ----------------
    logic [18:0] log [$];
    int          rise_cyc [$];
    logic [2:0]  rise_sel [$];
    int          done_cnt   = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) log.push_back({bus.out_chan, bus.out_data});
    end

    // Compare process: every output against the model on every falling edge.
    always @(negedge clk) begin
        check("sel",   {29'd0, s2, s0, s1}, {29'd0, m_sel});
        check("valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("data",  {16'd0, bus.out_data}, {16'd0, m_data});
        check("chan",  {29'd0, bus.out_chan}, {29'd0, m_chan});
        check("busy",  {31'd0, busy}, {31'd0, m_busy});
        check("done",  {31'd0, done}, {31'd0, m_done});
        if (done) done_cnt++;
        if (bus.out_valid && !prev_valid) begin
            rise_cyc.push_back(cyc);
            rise_sel.push_back({s2, s0, s1});
        end
        prev_valid = bus.out_valid;
    end

    // ---------------- directed helpers ----------------
    task automatic clear_logs();
        log.delete();
        rise_cyc.delete();
        rise_sel.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
        tick(2);
    endtask

    task automatic check_chans(input string tag, input int exp_n, input logic [2:0] c0, c1, c2);
        check({tag, "_count"}, log.size(), exp_n);
        while (log.size() < 3) log.push_back('1);
        check({tag, "_ch0"}, {29'd0, log[0][18:16]}, {29'd0, c0});
        check({tag, "_ch1"}, {29'd0, log[1][18:16]}, {29'd0, c1});
        if (exp_n > 2) check({tag, "_ch2"}, {29'd0, log[2][18:16]}, {29'd0, c2});
    endtask

    task automatic begin_scan(input logic [7:0] m, input logic cont, output int e0);
        chan_mask  = m;
        continuous = cont;
        start      = 1'b1;
        tick(1);
        e0    = cyc;
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int n;
        for (int i = 0; i < 8; i++) words[i] = 16'hA000 + 16'(i);
        bus.out_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_sel",   {29'd0, s2, s0, s1}, 32'd0);
        tick(1);

        // Basic pass over channels 0, 2, 7 with the consumer always ready.
        clear_logs();
        begin_scan(8'b1000_0101, 1'b0, e0);
        wait_idle(100);
        check("t1_rises", rise_cyc.size(), 3);
        while (rise_cyc.size() < 3) begin rise_cyc.push_back(0); rise_sel.push_back('1); end
        check("t1_rise0", rise_cyc[0] - e0, 2);
        check("t1_rise1", rise_cyc[1] - e0, 5);
        check("t1_rise2", rise_cyc[2] - e0, 8);
        check("t1_sel0", {29'd0, rise_sel[0]}, {29'd0, 3'b000});
        check("t1_sel1", {29'd0, rise_sel[1]}, {29'd0, 3'b010});
        check("t1_sel2", {29'd0, rise_sel[2]}, {29'd0, 3'b111});
        check("t1_done", done_cnt, 1);
        check_chans("t1", 3, 3'd0, 3'd2, 3'd7);
        check("t1_data0", {16'd0, log[0][15:0]}, 32'hA000);
        check("t1_data1", {16'd0, log[1][15:0]}, 32'hA002);
        check("t1_data2", {16'd0, log[2][15:0]}, 32'hA007);

        // Stall on channel 2 for five cycles.
        clear_logs();
        begin_scan(8'b1000_0101, 1'b0, e0);
        n = 0;
        while (!(bus.out_valid && bus.out_chan == 3'd2) && n < 50) begin tick(1); n++; end
        check("t2_reach", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("t2_hold_data", {16'd0, bus.out_data}, 32'hA002);
            check("t2_hold_sel", {29'd0, s2, s0, s1}, {29'd0, 3'b010});
        end
        bus.out_ready = 1'b1;
        wait_idle(100);
        check_chans("t2", 3, 3'd0, 3'd2, 3'd7);
        check("t2_done", done_cnt, 1);

        // Continuous 0,7,0,... aborted while channel 7 settles.
        clear_logs();
        begin_scan(8'h81, 1'b1, e0);
        n = 0;
        while (log.size() < 3 && n < 100) begin tick(1); n++; end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_sel", {29'd0, s2, s0, s1}, {29'd0, 3'b111});
        tick(3);
        check("t3_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t3_done_cnt", done_cnt, 1);
        check_chans("t3", 3, 3'd0, 3'd7, 3'd0);
        continuous = 1'b0;

        // Empty mask: a lone done pulse.
        clear_logs();
        begin_scan(8'h00, 1'b0, e0);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        tick(3);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_valid", {31'd0, bus.out_valid}, 32'd0);

        // Mid-scan start and mask change are ignored.
        clear_logs();
        begin_scan(8'b0100_1010, 1'b0, e0);
        tick(3);
        start      = 1'b1;
        chan_mask  = 8'hFF;
        continuous = 1'b1;
        tick(1);
        start      = 1'b0;
        continuous = 1'b0;
        wait_idle(100);
        check_chans("t5", 3, 3'd1, 3'd3, 3'd6);
        check("t5_done", done_cnt, 1);

        // Reset while a sample is pending in HOLD.
        bus.out_ready = 1'b0;
        begin_scan(8'h04, 1'b0, e0);
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(1); n++; end
        check("t6_valid_before", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_sel", {29'd0, s2, s0, s1}, 32'd0);
        check("t6_data", {16'd0, bus.out_data}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 2000; i++) begin
            start         = ($urandom_range(0, 9) == 0);
            stop          = ($urandom_range(0, 29) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            chan_mask     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            continuous    = ($urandom_range(0, 3) == 0);
            rst_n         = ($urandom_range(0, 199) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
